// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage: opcodes, FSM encoding and default widths.
package alu_pkg;

  localparam int DATA_W = 8;
  localparam int NREGS  = 4;
  localparam int RA_W   = 2;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_NOT = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_SHR = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OPER = 2'd1,
    WB   = 2'd2
  } state_t;

endpackage

// File: rtl/alu_regfile.sv
// Small register file: three asynchronous read ports, one synchronous write port,
// synchronous active-low clear of every entry.
module alu_regfile
  import alu_pkg::*;
#(
  parameter int NREGS  = alu_pkg::NREGS,
  parameter int DATA_W = alu_pkg::DATA_W,
  parameter int RA_W   = alu_pkg::RA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [RA_W-1:0]   wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [RA_W-1:0]   ra1,
  output logic [DATA_W-1:0] rd1,
  input  logic [RA_W-1:0]   ra2,
  output logic [DATA_W-1:0] rd2,
  input  logic [RA_W-1:0]   ra3,
  output logic [DATA_W-1:0] rd3
);

  logic [DATA_W-1:0] mem [NREGS];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) mem[i] <= '0;
    end else if (we) begin
      mem[wa] <= wd;
    end
  end

  assign rd1 = mem[ra1];
  assign rd2 = mem[ra2];
  assign rd3 = mem[ra3];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/operand stage for the 8-bit ALU: IDLE -> OPER -> WB, one instruction per 3 cycles.
// Optional zero/negative flags are built only when ALU_ISSUE_FLAGS_EN is defined.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int DATA_W = alu_pkg::DATA_W,
  parameter int NREGS  = alu_pkg::NREGS,
  parameter int RA_W   = alu_pkg::RA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  // Handshake: an instruction is taken at a rising edge where instr_valid and
  // instr_ready are both high; instr_* is ignored at every other edge.
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [2:0]        instr_op,
  input  logic [RA_W-1:0]   instr_rd,
  input  logic [RA_W-1:0]   instr_rs1,
  input  logic [RA_W-1:0]   instr_rs2,
  input  logic              instr_imm_sel,
  input  logic [DATA_W-1:0] instr_imm,
  output logic [DATA_W-1:0] regA,
  output logic [DATA_W-1:0] regB,
  output logic [2:0]        S,
  input  logic [DATA_W-1:0] M,
  output logic              wb_valid,
  output logic [RA_W-1:0]   wb_rd,
  output logic [DATA_W-1:0] wb_data,
  input  logic [RA_W-1:0]   dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic              flag_z,
  output logic              flag_n
);

  state_t            state;
  logic [DATA_W-1:0] res;
  logic [RA_W-1:0]   rd_q;
  logic [DATA_W-1:0] rs1_data;
  logic [DATA_W-1:0] rs2_data;

  // Write lands at the WB closing edge, before the earliest next operand read.
  alu_regfile #(
    .NREGS (NREGS),
    .DATA_W(DATA_W),
    .RA_W  (RA_W)
  ) u_rf (
    .clk  (clk),
    .rst_n(rst_n),
    .we   (state == WB),
    .wa   (rd_q),
    .wd   (res),
    .ra1  (instr_rs1),
    .rd1  (rs1_data),
    .ra2  (instr_rs2),
    .rd2  (rs2_data),
    .ra3  (dbg_addr),
    .rd3  (dbg_data)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      instr_ready <= 1'b1;
      regA        <= '0;
      regB        <= '0;
      S           <= '0;
      rd_q        <= '0;
      res         <= '0;
      wb_valid    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (instr_valid) begin
            regA        <= rs1_data;
            regB        <= instr_imm_sel ? instr_imm : rs2_data;
            S           <= instr_op;
            rd_q        <= instr_rd;
            instr_ready <= 1'b0;
            state       <= OPER;
          end
        end
        OPER: begin
          res      <= M;
          wb_valid <= 1'b1;
          state    <= WB;
        end
        WB: begin
          wb_valid    <= 1'b0;
          instr_ready <= 1'b1;
          state       <= IDLE;
        end
        default: begin
          wb_valid    <= 1'b0;
          instr_ready <= 1'b1;
          state       <= IDLE;
        end
      endcase
    end
  end

  assign wb_rd   = rd_q;
  assign wb_data = res;

`ifdef ALU_ISSUE_FLAGS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flag_z <= 1'b0;
      flag_n <= 1'b0;
    end else if (state == WB) begin
      flag_z <= (res == '0);
      flag_n <= res[DATA_W-1];
    end
  end
`else
  assign flag_z = 1'b0;
  assign flag_n = 1'b0;
`endif

endmodule
